// File: rtl/irq_entry_unit.sv
// Interrupt entry/return sequencer: takes a pending interrupt at a commit boundary,
// acknowledges it, flushes, redirects fetch to the handler and returns via EOI.
module irq_entry_unit #(
  parameter int PC_WIDTH     = 32,
  parameter int VECTOR_WIDTH = 8,
  parameter int VECTOR_SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    irq_pending,
  input  logic [3:0]              irq_num,
  input  logic [VECTOR_WIDTH-1:0] irq_vector,
  output logic                    irq_ack,
  output logic [3:0]              irq_ack_num,
  input  logic                    commit_valid,
  input  logic [PC_WIDTH-1:0]     commit_next_pc,
  input  logic                    iret_commit,
  input  logic                    pipe_empty,
  input  logic                    ie_set,
  input  logic                    ie_clr,
  output logic                    flush,
  output logic                    redirect_valid,
  output logic [PC_WIDTH-1:0]     redirect_pc,
  output logic                    eoi_valid,
  output logic [3:0]              eoi_num,
  output logic                    ie,
  output logic                    in_handler,
  output logic [PC_WIDTH-1:0]     epc,
  output logic                    spurious_iret
);

  localparam int WIDE_W = PC_WIDTH + VECTOR_WIDTH + VECTOR_SHIFT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_FLUSH,
    S_REDIRECT,
    S_HANDLER,
    S_RETURN
  } state_e;

  state_e                state_q;
  logic [3:0]            cur_num_q;
  logic [PC_WIDTH-1:0]   handler_pc_q;
  logic [PC_WIDTH-1:0]   handler_pc_w;
  logic                  take;

  // Widen before shifting so nothing is lost, then drop bits above PC_WIDTH.
  assign handler_pc_w = PC_WIDTH'(WIDE_W'(irq_vector) << VECTOR_SHIFT);
  assign take         = ie & ~ie_clr & irq_pending & commit_valid;
  assign in_handler   = (state_q == S_FLUSH) || (state_q == S_REDIRECT) ||
                        (state_q == S_HANDLER);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values and later defaults can be safely overridden below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cur_num_q      <= '0;
      handler_pc_q   <= '0;
      irq_ack        <= 1'b0;
      irq_ack_num    <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      eoi_valid      <= 1'b0;
      eoi_num        <= '0;
      ie             <= 1'b0;
      epc            <= '0;
      spurious_iret  <= 1'b0;
    end else begin
      irq_ack        <= 1'b0;
      redirect_valid <= 1'b0;
      eoi_valid      <= 1'b0;
      spurious_iret  <= iret_commit && (state_q != S_HANDLER);

      case (state_q)
        S_IDLE: begin
          if (ie_clr)      ie <= 1'b0;
          else if (ie_set) ie <= 1'b1;
          if (take) begin
            state_q      <= S_ACK;
            cur_num_q    <= irq_num;
            handler_pc_q <= handler_pc_w;
            epc          <= commit_next_pc;
            irq_ack      <= 1'b1;
            irq_ack_num  <= irq_num;
            flush        <= 1'b1;
          end
        end
        S_ACK: begin
          ie      <= 1'b0;
          state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          if (pipe_empty) begin
            flush          <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= handler_pc_q;
            state_q        <= S_REDIRECT;
          end
        end
        S_REDIRECT: state_q <= S_HANDLER;
        S_HANDLER: begin
          if (iret_commit) begin
            state_q        <= S_RETURN;
            eoi_valid      <= 1'b1;
            eoi_num        <= cur_num_q;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= epc;
          end
        end
        S_RETURN: begin
          flush   <= 1'b0;
          ie      <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          flush   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_entry_unit.sv
// Self-checking bench for irq_entry_unit: scenario tasks with randomized interrupts
// checked every cycle against a transaction-level expectation of all outputs.
module tb_irq_entry_unit;

  localparam int PC_WIDTH     = 32;
  localparam int VECTOR_WIDTH = 8;
  localparam int VECTOR_SHIFT = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    irq_pending;
  logic [3:0]              irq_num;
  logic [VECTOR_WIDTH-1:0] irq_vector;
  logic                    irq_ack;
  logic [3:0]              irq_ack_num;
  logic                    commit_valid;
  logic [PC_WIDTH-1:0]     commit_next_pc;
  logic                    iret_commit;
  logic                    pipe_empty;
  logic                    ie_set;
  logic                    ie_clr;
  logic                    flush;
  logic                    redirect_valid;
  logic [PC_WIDTH-1:0]     redirect_pc;
  logic                    eoi_valid;
  logic [3:0]              eoi_num;
  logic                    ie;
  logic                    in_handler;
  logic [PC_WIDTH-1:0]     epc;
  logic                    spurious_iret;

  irq_entry_unit #(
    .PC_WIDTH    (PC_WIDTH),
    .VECTOR_WIDTH(VECTOR_WIDTH),
    .VECTOR_SHIFT(VECTOR_SHIFT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .irq_pending   (irq_pending),
    .irq_num       (irq_num),
    .irq_vector    (irq_vector),
    .irq_ack       (irq_ack),
    .irq_ack_num   (irq_ack_num),
    .commit_valid  (commit_valid),
    .commit_next_pc(commit_next_pc),
    .iret_commit   (iret_commit),
    .pipe_empty    (pipe_empty),
    .ie_set        (ie_set),
    .ie_clr        (ie_clr),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .eoi_valid     (eoi_valid),
    .eoi_num       (eoi_num),
    .ie            (ie),
    .in_handler    (in_handler),
    .epc           (epc),
    .spurious_iret (spurious_iret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                ack;
    logic [3:0]          ack_num;
    logic                flush;
    logic                rv;
    logic [PC_WIDTH-1:0] rpc;
    logic                eoi;
    logic [3:0]          eoi_num;
    logic                ie;
    logic                inh;
    logic [PC_WIDTH-1:0] epc;
    logic                spur;
  } out_t;

  int checks   = 0;
  int failures = 0;

  // Model of the values the unit holds between strobes.
  logic [3:0]          m_ack_num;
  logic [3:0]          m_eoi_num;
  logic [PC_WIDTH-1:0] m_rpc;
  logic [PC_WIDTH-1:0] m_epc;
  logic                m_ie;

  out_t o, e;

  function automatic out_t sample();
    return '{irq_ack, irq_ack_num, flush, redirect_valid, redirect_pc,
             eoi_valid, eoi_num, ie, in_handler, epc, spurious_iret};
  endfunction

  function automatic out_t expv(input logic a, input logic f, input logic rv,
                                input logic eo, input logic inh, input logic sp);
    return '{a, m_ack_num, f, rv, m_rpc, eo, m_eoi_num, m_ie, inh, m_epc, sp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    irq_pending    = 1'b0;
    irq_num        = '0;
    irq_vector     = '0;
    commit_valid   = 1'b0;
    commit_next_pc = '0;
    iret_commit    = 1'b0;
    pipe_empty     = 1'b1;
    ie_set         = 1'b0;
    ie_clr         = 1'b0;
  endtask

  task automatic model_reset();
    m_ack_num = '0; m_eoi_num = '0; m_rpc = '0; m_epc = '0; m_ie = 1'b0;
  endtask

  // Full interrupt round trip; requires IDLE with ie=1 on entry, leaves IDLE with ie=1.
  task automatic run_irq(input logic [3:0] num, input logic [7:0] vec,
                         input logic [PC_WIDTH-1:0] pc, input logic [3:0] alt_num,
                         input int w, input int hlen, input bit spur_in_flush);
    logic [PC_WIDTH-1:0] hpc;
    logic                sp;
    hpc = PC_WIDTH'(64'(vec) << VECTOR_SHIFT);
    irq_pending = 1'b1; irq_num = num; irq_vector = vec; commit_valid = 1'b1;
    commit_next_pc = pc; pipe_empty = 1'($urandom); iret_commit = 1'b0;
    ie_set = 1'($urandom); ie_clr = 1'b0;
    tick();
    m_ack_num = num; m_epc = pc;
    checks++; o = sample(); e = expv(1, 1, 0, 0, 0, 0);
    if (o !== e) begin failures++; $display("FAIL ack: got %h exp %h", o, e); end
    // Controller inputs move on; only latched values may be used from here.
    irq_num = alt_num; irq_vector = 8'($urandom); commit_next_pc = $urandom;
    ie_set = 1'($urandom); ie_clr = 1'($urandom); pipe_empty = 1'($urandom);
    tick();
    m_ie = 1'b0;
    checks++; o = sample(); e = expv(0, 1, 0, 0, 1, 0);
    if (o !== e) begin failures++; $display("FAIL flush_enter: got %h exp %h", o, e); end
    for (int i = 0; i < w; i++) begin
      pipe_empty = 1'b0;
      iret_commit = spur_in_flush ? 1'($urandom) : 1'b0;
      sp = iret_commit;
      tick();
      checks++; o = sample(); e = expv(0, 1, 0, 0, 1, sp);
      if (o !== e) begin failures++; $display("FAIL flush_hold: got %h exp %h", o, e); end
    end
    pipe_empty = 1'b1; iret_commit = 1'b0;
    tick();
    m_rpc = hpc;
    checks++; o = sample(); e = expv(0, 0, 1, 0, 1, 0);
    if (o !== e) begin failures++; $display("FAIL redirect: got %h exp %h", o, e); end
    tick();
    checks++; o = sample(); e = expv(0, 0, 0, 0, 1, 0);
    if (o !== e) begin failures++; $display("FAIL handler: got %h exp %h", o, e); end
    for (int i = 0; i < hlen; i++) begin
      irq_pending = 1'b1; commit_valid = 1'b1; irq_num = 4'($urandom);
      ie_set = 1'($urandom); ie_clr = 1'($urandom);
      tick();
      checks++; o = sample(); e = expv(0, 0, 0, 0, 1, 0);
      if (o !== e) begin failures++; $display("FAIL no_nest: got %h exp %h", o, e); end
    end
    iret_commit = 1'b1;
    tick();
    m_eoi_num = num; m_rpc = pc;
    checks++; o = sample(); e = expv(0, 1, 1, 1, 0, 0);
    if (o !== e) begin failures++; $display("FAIL return: got %h exp %h", o, e); end
    idle_inputs();
    tick();
    m_ie = 1'b1;
    checks++; o = sample(); e = expv(0, 0, 0, 0, 0, 0);
    if (o !== e) begin failures++; $display("FAIL resume: got %h exp %h", o, e); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; o = sample(); e = expv(0, 0, 0, 0, 0, 0);
    if (o !== e) begin failures++; $display("FAIL reset: got %h exp %h", o, e); end
    rst_n = 1'b1;
    tick();
    checks++; o = sample(); e = expv(0, 0, 0, 0, 0, 0);
    if (o !== e) begin failures++; $display("FAIL post_reset: got %h exp %h", o, e); end
  endtask

  task automatic test_ie_control();
    ie_set = 1'b1; tick(); m_ie = 1'b1;
    checks++; o = sample(); e = expv(0, 0, 0, 0, 0, 0);
    if (o !== e) begin failures++; $display("FAIL ie_set: got %h exp %h", o, e); end
    ie_clr = 1'b1; tick(); m_ie = 1'b0;
    checks++; o = sample(); e = expv(0, 0, 0, 0, 0, 0);
    if (o !== e) begin failures++; $display("FAIL ie_clr_wins: got %h exp %h", o, e); end
    ie_clr = 1'b0; tick(); m_ie = 1'b1;
    ie_set = 1'b0;
    ie_clr = 1'b1; irq_pending = 1'b1; commit_valid = 1'b1; irq_num = 4'd3;
    commit_next_pc = $urandom;
    tick(); m_ie = 1'b0;
    checks++; o = sample(); e = expv(0, 0, 0, 0, 0, 0);
    if (o !== e) begin failures++; $display("FAIL clr_blocks_take: got %h exp %h", o, e); end
    ie_clr = 1'b0; tick();
    checks++; o = sample(); e = expv(0, 0, 0, 0, 0, 0);
    if (o !== e) begin failures++; $display("FAIL ie0_blocks: got %h exp %h", o, e); end
    idle_inputs(); ie_set = 1'b1; tick(); m_ie = 1'b1;
    ie_set = 1'b0;
  endtask

  task automatic test_gating();
    for (int i = 0; i < 8; i++) begin
      irq_pending    = 1'($urandom);
      commit_valid   = irq_pending ? 1'b0 : 1'($urandom);
      irq_num        = 4'($urandom);
      commit_next_pc = $urandom;
      tick();
      checks++; o = sample(); e = expv(0, 0, 0, 0, 0, 0);
      if (o !== e) begin failures++; $display("FAIL gate: got %h exp %h", o, e); end
    end
    idle_inputs();
  endtask

  task automatic test_spurious();
    iret_commit = 1'b1; tick(); iret_commit = 1'b0;
    checks++; o = sample(); e = expv(0, 0, 0, 0, 0, 1);
    if (o !== e) begin failures++; $display("FAIL spurious: got %h exp %h", o, e); end
    tick();
    checks++; o = sample(); e = expv(0, 0, 0, 0, 0, 0);
    if (o !== e) begin failures++; $display("FAIL spurious_end: got %h exp %h", o, e); end
  endtask

  task automatic test_basic_entry();
    run_irq(4'd5, 8'h40, 32'h0000_1000, 4'd9, 0, 2, 1'b0);
  endtask

  task automatic test_flush_wait();
    run_irq(4'd5, 8'h40, 32'h0000_1000, 4'd9, 4, 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_irq(4'd15, 8'hFF, 32'hFFFF_FFFF, 4'd0, 0, 0, 1'b0);
    run_irq(4'd0, 8'h00, 32'h0000_0000, 4'd15, 1, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      run_irq(4'($urandom), 8'($urandom), $urandom, 4'($urandom),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), 1'b1);
      repeat (int'($urandom_range(0, 2))) begin
        irq_pending = 1'($urandom); commit_valid = 1'b0;
        tick();
        checks++; o = sample(); e = expv(0, 0, 0, 0, 0, 0);
        if (o !== e) begin failures++; $display("FAIL idle_gap: got %h exp %h", o, e); end
      end
      idle_inputs();
    end
  endtask

  task automatic test_reset_mid_flush();
    irq_pending = 1'b1; irq_num = 4'd7; irq_vector = 8'h21; commit_valid = 1'b1;
    commit_next_pc = 32'h0000_2468;
    tick();
    idle_inputs(); pipe_empty = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; o = sample(); e = expv(0, 0, 0, 0, 0, 0);
    if (o !== e) begin failures++; $display("FAIL async_reset: got %h exp %h", o, e); end
    @(posedge clk);
    #1 rst_n = 1'b1; idle_inputs(); ie_set = 1'b1;
    tick(); m_ie = 1'b1; ie_set = 1'b0;
    checks++; o = sample(); e = expv(0, 0, 0, 0, 0, 0);
    if (o !== e) begin failures++; $display("FAIL reset_release: got %h exp %h", o, e); end
    run_irq(4'd11, 8'h3C, 32'h0000_4000, 4'd2, 2, 1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ie_control();
    test_gating();
    test_spurious();
    test_basic_entry();
    test_flush_wait();
    test_spurious();
    test_back_to_back();
    test_random();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
